// File: rtl/iobuf_bank_pkg.sv
// iobuf_bank_pkg: shared types and widths for the IOBUF bank controller.
package iobuf_bank_pkg;

  // Requested pad mode as it arrives on the config bus
  typedef enum logic [1:0] {
    IN   = 2'b00,
    PP   = 2'b01,
    OD   = 2'b10,
    RSVD = 2'b11
  } mode_e;

  // Per-channel controller state
  typedef enum logic [1:0] {
    ST_IN   = 2'b00,
    ST_PP   = 2'b01,
    ST_OD   = 2'b10,
    ST_TURN = 2'b11
  } state_e;

  // Turnaround counter covers TURN_CYCLES up to 15
  localparam int unsigned TURN_CW = 4;
  // Fill counter covers SYNC_STAGES up to 4
  localparam int unsigned FILL_CW = 3;

  // Channel-select width; a single channel still gets a 1-bit select
  function automatic int unsigned chan_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iobuf_bank_ctrl_if.sv
// iobuf_bank_ctrl_if: config handshake plus fabric-side data of the pad bank.
interface iobuf_bank_ctrl_if #(
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CW = iobuf_bank_pkg::chan_w(CHANNELS);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CW-1:0]       cfg_chan;
  logic [1:0]          cfg_mode;
  logic [CHANNELS-1:0] wr_data;
  logic [CHANNELS-1:0] rd_data;
  logic [CHANNELS-1:0] rd_valid;

  // Fabric user side
  modport master (
    output cfg_valid, cfg_chan, cfg_mode, wr_data,
    input  cfg_ready, rd_data, rd_valid
  );

  // Controller side
  modport slave (
    input  cfg_valid, cfg_chan, cfg_mode, wr_data,
    output cfg_ready, rd_data, rd_valid
  );

endinterface

// File: rtl/iobuf_chan.sv
// iobuf_chan: one pad channel - mode FSM, turnaround counter, input
// synchroniser, fill counter. Optional input glitch filter selected by
// IOBUF_GLITCH_FILTER_EN.
module iobuf_chan
  import iobuf_bank_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  cfg_hit,
  input  mode_e cfg_mode,
  input  logic  wr_bit,
  input  logic  pad_in,
  output logic  pad_o,
  output logic  pad_t,
  output logic  rd_data,
  output logic  rd_valid,
  output logic  in_turn_c
);

  state_e                 st;
  state_e                 st_nxt;
  mode_e                  req;
  logic [TURN_CW-1:0]     turn_cnt;
  logic [FILL_CW-1:0]     fill_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sampling;

  assign in_turn_c = (st == ST_TURN);

  // Next-state decode; reserved mode behaves as input
  always_comb begin
    req    = (cfg_mode == RSVD) ? IN : cfg_mode;
    st_nxt = st;
    case (st)
      ST_IN: begin
        if (cfg_hit && req == PP)      st_nxt = ST_PP;
        else if (cfg_hit && req == OD) st_nxt = ST_OD;
      end
      ST_PP: begin
        if (cfg_hit && req == OD)      st_nxt = ST_OD;
        else if (cfg_hit && req == IN) st_nxt = ST_TURN;
      end
      ST_OD: begin
        if (cfg_hit && req == PP)      st_nxt = ST_PP;
        else if (cfg_hit && req == IN) st_nxt = ST_TURN;
      end
      ST_TURN: begin
        if (turn_cnt == '0)            st_nxt = ST_IN;
      end
      default: st_nxt = ST_IN;
    endcase
  end

  // Fill counting restarts whenever the channel enters IN/OD
  assign sampling = (st_nxt == st) && (st_nxt == ST_IN || st_nxt == ST_OD);

  // State, turnaround counter, registered pad drive and rd_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IN;
      turn_cnt <= '0;
      fill_cnt <= '0;
      pad_o    <= 1'b0;
      pad_t    <= 1'b1;
      rd_valid <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st != ST_TURN && st_nxt == ST_TURN)
        turn_cnt <= TURN_CW'(TURN_CYCLES - 1);
      else if (st == ST_TURN && turn_cnt != '0)
        turn_cnt <= turn_cnt - TURN_CW'(1);
      pad_o <= (st_nxt == ST_PP) ? wr_bit : 1'b0;
      pad_t <= (st_nxt == ST_PP) ? 1'b0 : ((st_nxt == ST_OD) ? wr_bit : 1'b1);
      if (!sampling) begin
        fill_cnt <= '0;
        rd_valid <= 1'b0;
      end else begin
        if (fill_cnt < FILL_CW'(SYNC_STAGES - 1))
          fill_cnt <= fill_cnt + FILL_CW'(1);
        rd_valid <= (fill_cnt >= FILL_CW'(SYNC_STAGES - 1));
      end
    end
  end

  // Pad input synchroniser, runs in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
  end

`ifdef IOBUF_GLITCH_FILTER_EN
  logic sync_d;

  // Accept a value once it spans the stage ahead, the output and the
  // previous output, i.e. it occupies the output for three cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d  <= 1'b0;
      rd_data <= 1'b0;
    end else begin
      sync_d <= sync_q[SYNC_STAGES-1];
      if (sync_q[SYNC_STAGES-2] == sync_q[SYNC_STAGES-1] &&
          sync_q[SYNC_STAGES-1] == sync_d)
        rd_data <= sync_q[SYNC_STAGES-1];
    end
  end
`else
  assign rd_data = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/iobuf_bank_ctrl.sv
// iobuf_bank_ctrl: mode controller for a bank of bidirectional pads.
// Decodes the config target and muxes cfg_ready; per-pad logic lives in
// iobuf_chan. pad_o/pad_t/pad_i connect to the I/T/O pins of the pad IOBUFs.
// Optional input glitch filter: define IOBUF_GLITCH_FILTER_EN.
module iobuf_bank_ctrl
  import iobuf_bank_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  iobuf_bank_ctrl_if.slave    bus,
  input  logic [CHANNELS-1:0] pad_i,
  output logic [CHANNELS-1:0] pad_o,
  output logic [CHANNELS-1:0] pad_t
);

  localparam int unsigned CW = chan_w(CHANNELS);

  logic [CHANNELS-1:0] turn_c;
  logic [CHANNELS-1:0] hit_c;
  logic [CHANNELS-1:0] rd_data_w;
  logic [CHANNELS-1:0] rd_valid_w;
  logic                ready_c;

  // Busy only when the addressed channel is turning around; an
  // out-of-range channel never matches and is always ready
  always_comb begin
    ready_c = 1'b1;
    for (int unsigned k = 0; k < CHANNELS; k++)
      if (bus.cfg_chan == CW'(k) && turn_c[k]) ready_c = 1'b0;
  end

  // One-hot accept strobe per channel
  always_comb begin
    hit_c = '0;
    for (int unsigned k = 0; k < CHANNELS; k++)
      hit_c[k] = bus.cfg_valid && ready_c && (bus.cfg_chan == CW'(k));
  end

  assign bus.cfg_ready = ready_c;
  assign bus.rd_data   = rd_data_w;
  assign bus.rd_valid  = rd_valid_w;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    iobuf_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .TURN_CYCLES (TURN_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_hit   (hit_c[g]),
      .cfg_mode  (mode_e'(bus.cfg_mode)),
      .wr_bit    (bus.wr_data[g]),
      .pad_in    (pad_i[g]),
      .pad_o     (pad_o[g]),
      .pad_t     (pad_t[g]),
      .rd_data   (rd_data_w[g]),
      .rd_valid  (rd_valid_w[g]),
      .in_turn_c (turn_c[g])
    );
  end

endmodule

// File: tb/tb_iobuf_bank_ctrl.sv
// tb_iobuf_bank_ctrl: directed vectors for the pad bank controller, plus
// hand sequences for turnaround, reset abort, out-of-range channel and filter.
module tb_iobuf_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pad_i;
  logic [3:0] pad_o;
  logic [3:0] pad_t;
  logic [4:0] pad5_i;
  logic [4:0] pad5_o;
  logic [4:0] pad5_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iobuf_bank_ctrl_if #(.CHANNELS(4)) bus ();
  iobuf_bank_ctrl_if #(.CHANNELS(5)) bus5 ();

  iobuf_bank_ctrl #(.CHANNELS(4), .SYNC_STAGES(2), .TURN_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pad_i(pad_i), .pad_o(pad_o), .pad_t(pad_t)
  );

  iobuf_bank_ctrl #(.CHANNELS(5), .SYNC_STAGES(2), .TURN_CYCLES(2)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5), .pad_i(pad5_i), .pad_o(pad5_o), .pad_t(pad5_t)
  );

  typedef struct {
    logic       v;
    logic [1:0] ch;
    logic [1:0] md;
    logic [3:0] wr;
    logic [3:0] pi;
    logic       rdy;
    logic [3:0] t;
    logic [3:0] o;
    logic [3:0] rv;
    logic [3:0] rd;
  } vec_t;

  localparam int NV = 29;
  vec_t vt [NV];

  function automatic vec_t mk(input logic v, input logic [1:0] ch, input logic [1:0] md,
                              input logic [3:0] wr, input logic [3:0] pi, input logic rdy,
                              input logic [3:0] t, input logic [3:0] o,
                              input logic [3:0] rv, input logic [3:0] rd);
    vec_t r;
    r.v = v; r.ch = ch; r.md = md; r.wr = wr; r.pi = pi;
    r.rdy = rdy; r.t = t; r.o = o; r.rv = rv; r.rd = rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            v  ch  md  wr    pi    rdy t     o     rv    rd
    vt[0]  = mk(0, 0, 0, 4'h0, 4'hA, 1, 4'hF, 4'h0, 4'h0, 4'h0);
    vt[1]  = mk(0, 0, 0, 4'h0, 4'hA, 1, 4'hF, 4'h0, 4'hF, 4'hA);
    vt[2]  = mk(1, 1, 1, 4'h0, 4'hA, 1, 4'hD, 4'h0, 4'hD, 4'hA); // ch1 -> PP
    vt[3]  = mk(0, 1, 0, 4'h2, 4'hA, 1, 4'hD, 4'h2, 4'hD, 4'hA);
    vt[4]  = mk(0, 1, 0, 4'h0, 4'hA, 1, 4'hD, 4'h0, 4'hD, 4'hA);
    vt[5]  = mk(0, 1, 0, 4'h2, 4'hA, 1, 4'hD, 4'h2, 4'hD, 4'hA);
    vt[6]  = mk(1, 1, 0, 4'h2, 4'hA, 1, 4'hF, 4'h0, 4'hD, 4'hA); // ch1 -> TURN
    vt[7]  = mk(1, 1, 1, 4'h2, 4'hA, 0, 4'hF, 4'h0, 4'hD, 4'hA); // blocked
    vt[8]  = mk(1, 1, 2, 4'h2, 4'hA, 0, 4'hF, 4'h0, 4'hD, 4'hA); // blocked, -> IN
    vt[9]  = mk(0, 1, 0, 4'h2, 4'hA, 1, 4'hF, 4'h0, 4'hD, 4'hA);
    vt[10] = mk(0, 1, 0, 4'h2, 4'hA, 1, 4'hF, 4'h0, 4'hF, 4'hA); // 2+SYNC after accept
    vt[11] = mk(1, 0, 2, 4'h0, 4'hA, 1, 4'hE, 4'h0, 4'hE, 4'hA); // ch0 -> OD
    vt[12] = mk(0, 0, 0, 4'h0, 4'hA, 1, 4'hE, 4'h0, 4'hE, 4'hA);
    vt[13] = mk(0, 0, 0, 4'h0, 4'hA, 1, 4'hE, 4'h0, 4'hF, 4'hA);
    vt[14] = mk(0, 0, 0, 4'h1, 4'hB, 1, 4'hF, 4'h0, 4'hF, 4'hA); // release, pad high
    vt[15] = mk(0, 0, 0, 4'h1, 4'hB, 1, 4'hF, 4'h0, 4'hF, 4'hB);
    vt[16] = mk(0, 0, 0, 4'h0, 4'hA, 1, 4'hE, 4'h0, 4'hF, 4'hB); // pull low
    vt[17] = mk(0, 0, 0, 4'h0, 4'hA, 1, 4'hE, 4'h0, 4'hF, 4'hA);
    vt[18] = mk(1, 2, 1, 4'h0, 4'hA, 1, 4'hA, 4'h0, 4'hB, 4'hA); // ch2 -> PP
    vt[19] = mk(1, 2, 3, 4'h4, 4'hA, 1, 4'hE, 4'h0, 4'hB, 4'hA); // reserved -> TURN
    vt[20] = mk(0, 2, 0, 4'h4, 4'hA, 0, 4'hE, 4'h0, 4'hB, 4'hA);
    vt[21] = mk(0, 2, 0, 4'h4, 4'hA, 0, 4'hE, 4'h0, 4'hB, 4'hA);
    vt[22] = mk(0, 2, 0, 4'h4, 4'hA, 1, 4'hE, 4'h0, 4'hB, 4'hA);
    vt[23] = mk(0, 2, 0, 4'h4, 4'hA, 1, 4'hE, 4'h0, 4'hF, 4'hA);
    vt[24] = mk(1, 0, 2, 4'h0, 4'hA, 1, 4'hE, 4'h0, 4'hF, 4'hA); // same mode: no-op
    vt[25] = mk(1, 0, 1, 4'h1, 4'hA, 1, 4'hE, 4'h1, 4'hE, 4'hA); // OD -> PP
    vt[26] = mk(1, 0, 2, 4'h1, 4'hA, 1, 4'hF, 4'h0, 4'hE, 4'hA); // PP -> OD, wr=1
    vt[27] = mk(0, 0, 0, 4'h1, 4'hA, 1, 4'hF, 4'h0, 4'hE, 4'hA);
    vt[28] = mk(0, 0, 0, 4'h1, 4'hA, 1, 4'hF, 4'h0, 4'hF, 4'hA);

    rst_n = 1'b0;
    pad_i = 4'hA;
    pad5_i = 5'h0;
    bus.cfg_valid = 1'b0; bus.cfg_chan = 2'd0; bus.cfg_mode = 2'd0; bus.wr_data = 4'h0;
    bus5.cfg_valid = 1'b0; bus5.cfg_chan = 3'd0; bus5.cfg_mode = 2'd0; bus5.wr_data = 5'h0;

    // Reset state
    repeat (2) tick();
    chk("rst pad_t",    8'(pad_t),        8'hF);
    chk("rst pad_o",    8'(pad_o),        8'h0);
    chk("rst rd_data",  8'(bus.rd_data),  8'h0);
    chk("rst rd_valid", 8'(bus.rd_valid), 8'h0);
    chk("rst pad5_t",   8'(pad5_t),       8'h1F);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < NV; i++) begin
      bus.cfg_valid = vt[i].v;
      bus.cfg_chan  = vt[i].ch;
      bus.cfg_mode  = vt[i].md;
      bus.wr_data   = vt[i].wr;
      pad_i         = vt[i].pi;
      #1;
      chk($sformatf("v%0d ready", i), 8'(bus.cfg_ready), 8'(vt[i].rdy));
      tick();
      chk($sformatf("v%0d pad_t", i),    8'(pad_t),        8'(vt[i].t));
      chk($sformatf("v%0d pad_o", i),    8'(pad_o),        8'(vt[i].o));
      chk($sformatf("v%0d rd_valid", i), 8'(bus.rd_valid), 8'(vt[i].rv));
`ifndef IOBUF_GLITCH_FILTER_EN
      chk($sformatf("v%0d rd_data", i),  8'(bus.rd_data),  8'(vt[i].rd));
`endif
    end
    bus.cfg_valid = 1'b0;

    // Turnaround window: ch1 busy, ch2 still configurable
    bus.cfg_valid = 1'b1; bus.cfg_chan = 2'd1; bus.cfg_mode = 2'd1;
    tick();
    bus.cfg_mode = 2'd0;
    tick();
    chk("turn ch1 pad_t", 8'(pad_t[1]), 8'h1);
    for (int i = 0; i < 2; i++) begin
      bus.cfg_valid = 1'b0; bus.cfg_chan = 2'd1;
      #1;
      chk($sformatf("turn ch1 busy %0d", i), 8'(bus.cfg_ready), 8'h0);
      bus.cfg_valid = 1'b1; bus.cfg_chan = 2'd2; bus.cfg_mode = (i == 0) ? 2'd1 : 2'd0;
      #1;
      chk($sformatf("turn ch2 ready %0d", i), 8'(bus.cfg_ready), 8'h1);
      tick();
      chk($sformatf("turn ch2 pad_t %0d", i), 8'(pad_t[2]), (i == 0) ? 8'h0 : 8'h1);
      chk($sformatf("turn ch1 hiz %0d", i),   8'(pad_t[1]), 8'h1);
    end
    bus.cfg_valid = 1'b0; bus.cfg_chan = 2'd1;
    #1;
    chk("turn ch1 back ready", 8'(bus.cfg_ready), 8'h1);
    repeat (3) tick();

    // Reset asserted mid-turnaround
    bus.cfg_valid = 1'b1; bus.cfg_chan = 2'd1; bus.cfg_mode = 2'd1;
    tick();
    bus.cfg_mode = 2'd0;
    tick();
    bus.cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort pad_t",    8'(pad_t),         8'hF);
    chk("abort pad_o",    8'(pad_o),         8'h0);
    chk("abort rd_valid", 8'(bus.rd_valid),  8'h0);
    chk("abort ready",    8'(bus.cfg_ready), 8'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort rv e1", 8'(bus.rd_valid), 8'h0);
    tick();
    chk("abort rv e2", 8'(bus.rd_valid), 8'hF);

    // Out-of-range channel on a 5-channel bank
    bus5.cfg_valid = 1'b1; bus5.cfg_mode = 2'd1;
    for (int i = 5; i < 8; i++) begin
      bus5.cfg_chan = 3'(i);
      #1;
      chk($sformatf("oor ready %0d", i), 8'(bus5.cfg_ready), 8'h1);
      tick();
      chk($sformatf("oor pad_t %0d", i), 8'(pad5_t), 8'h1F);
      chk($sformatf("oor pad_o %0d", i), 8'(pad5_o), 8'h0);
    end
    bus5.cfg_chan = 3'd4;
    tick();
    chk("ch4 pp pad_t", 8'(pad5_t), 8'h0F);
    bus5.cfg_valid = 1'b0;
    repeat (4) tick();

    // Short pulses on pad 3 (idle high)
    chk("pulse pre", 8'(bus.rd_data[3]), 8'h1);
`ifdef IOBUF_GLITCH_FILTER_EN
    pad_i[3] = 1'b0;
    tick();
    pad_i[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("glitch1 e%0d", k), 8'(bus.rd_data[3]), 8'h1);
    end
    pad_i[3] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("glitch3 e%0d", k), 8'(bus.rd_data[3]),
          (k >= 4 && k <= 6) ? 8'h0 : 8'h1);
      if (k == 3) pad_i[3] = 1'b1;
    end
`else
    pad_i[3] = 1'b0;
    tick();
    pad_i[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("pulse e%0d", k), 8'(bus.rd_data[3]), (k == 2) ? 8'h0 : 8'h1);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
